// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the front-panel seven-segment driver.
// Segment vectors are active-low with bit 0 = a through bit 6 = g.
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low hex glyphs 0..F (A, b, C, d, E, F for the letters)
    localparam seg_t HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with a dark override.
// Ports: nibble  - hex value to show
//        dark    - 1 forces every segment off
//        seg_c   - active-low segment pattern
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  nibble_t nibble,
    input  logic    dark,
    output seg_t    seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        if (!dark) begin
            seg_c = HEX_GLYPH[nibble];
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with a double-buffered frame,
// per-digit blank/blink, leading-zero suppression and tear-free commit.
// Ports: clk, reset_n (async active-low)
//        digits_in/blank_in/blink_in - frame data captured on load
//        lz_suppress - live leading-zero suppression enable
//        load        - one-cycle capture strobe
//        load_ack    - pulse when the new frame becomes visible
//        frame_start - pulse on the first output cycle of digit 0
//        seg_n/an_n  - active-low segments and digit enables
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output seg_t                    seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRE_W-1:0]            pre_cnt;
    logic [IDX_W-1:0]            idx;
    logic [FRM_W-1:0]            frm_cnt;
    logic                        blink_phase;
    logic                        pend;
    logic                        wrap_q;
    logic                        ack_q;

    nibble_t [NUM_DIGITS-1:0]    act_nib;
    logic    [NUM_DIGITS-1:0]    act_blank;
    logic    [NUM_DIGITS-1:0]    act_blink;
    nibble_t [NUM_DIGITS-1:0]    pnd_nib;
    logic    [NUM_DIGITS-1:0]    pnd_blank;
    logic    [NUM_DIGITS-1:0]    pnd_blink;

    logic                        tick;
    logic                        frame_wrap;
    logic                        lz_run;
    logic    [NUM_DIGITS-1:0]    lz_dark;
    logic                        dark_c;
    seg_t                        glyph_c;
    logic    [NUM_DIGITS-1:0]    an_c;

    assign tick       = (pre_cnt == PRE_W'(SCAN_DIV - 1));
    assign frame_wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    // Prescaler and scan index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            idx     <= frame_wrap ? '0 : idx + IDX_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Blink half-period counter, advanced once per frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_cnt     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frm_cnt <= frm_cnt + FRM_W'(1);
            end
        end
    end

    // Double buffer: a load landing on the boundary bypasses the pending copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_nib   <= '0;
            act_blank <= '0;
            act_blink <= '0;
            pnd_nib   <= '0;
            pnd_blank <= '0;
            pnd_blink <= '0;
            pend      <= 1'b0;
            ack_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= frame_wrap;
            ack_q  <= frame_wrap && (load || pend);
            if (frame_wrap && load) begin
                act_nib   <= digits_in;
                act_blank <= blank_in;
                act_blink <= blink_in;
                pend      <= 1'b0;
            end else if (frame_wrap && pend) begin
                act_nib   <= pnd_nib;
                act_blank <= pnd_blank;
                act_blink <= pnd_blink;
                pend      <= 1'b0;
            end else if (load) begin
                pnd_nib   <= digits_in;
                pnd_blank <= blank_in;
                pnd_blink <= blink_in;
                pend      <= 1'b1;
            end
        end
    end

    // Leading-zero mask: dark from the top digit down to the first nonzero one
    always_comb begin
        lz_run  = lz_suppress;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run & (act_blank[i] | (act_nib[i] == 4'h0));
            lz_dark[i] = lz_run;
        end
    end

    assign dark_c = act_blank[idx] | (act_blink[idx] & blink_phase) | lz_dark[idx];

    always_comb begin
        an_c = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_c[i] = (idx != IDX_W'(i));
        end
    end

    seven_seg_hex_decode u_decode (
        .nibble (act_nib[idx]),
        .dark   (dark_c),
        .seg_c  (glyph_c)
    );

    // Registered outputs; pulses are delayed one cycle to line up with digit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_n       <= SEG_OFF;
            an_n        <= '1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= glyph_c;
            an_n        <= an_c;
            load_ack    <= ack_q;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (4 digits, 4 cycles/slot, 2 frames/blink).
module tb_seven_seg_scan;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic        lz_suppress = 1'b0;
    logic        load = 1'b0;
    logic        load_ack;
    logic        frame_start;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    seven_seg_scan #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (S),
        .BLINK_FRAMES (B)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .lz_suppress (lz_suppress),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .seg_n       (seg_n),
        .an_n        (an_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       ack;
        logic       fs;
    } obs_t;

    obs_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ack_cnt = 0;
    string phase_tag = "init";

    // Reference state: k counts rising edges since reset release
    int          k = 0;
    logic [15:0] m_dig = '0, p_dig = '0;
    logic [3:0]  m_blank = '0, m_blink = '0, p_blank = '0, p_blink = '0;
    bit          m_pend = 0, prev_bnd = 0, prev_ack = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Lit segments listed as gfedcba, then inverted for the active-low bus
    function automatic logic [6:0] ref_glyph(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        bit dark;
        bit all_zero;
        int phase;
        phase = ((k / (S * N)) / B) % 2;
        dark  = m_blank[d] || (m_blink[d] && phase == 1);
        if (lz_suppress && d > 0) begin
            all_zero = 1;
            for (int j = d; j < N; j++) begin
                if (!(m_blank[j] || m_dig[4*j +: 4] == 4'h0)) all_zero = 0;
            end
            if (all_zero) dark = 1;
        end
        return dark ? 7'h7F : ref_glyph(m_dig[4*d +: 4]);
    endfunction

    function automatic bit next_is_bnd();
        return (k % S == S - 1) && ((k / S) % N == N - 1);
    endfunction

    task automatic model_clear();
        k = 0; m_dig = '0; m_blank = '0; m_blink = '0;
        p_dig = '0; p_blank = '0; p_blink = '0;
        m_pend = 0; prev_bnd = 0; prev_ack = 0;
        sb_q.delete();
    endtask

    // One clock: predict this edge's outputs, advance the model, then compare
    task automatic step();
        obs_t e;
        obs_t o;
        int   d;
        bit   bnd;
        @(posedge clk);
        d   = (k / S) % N;
        bnd = next_is_bnd();
        e.seg = ref_seg(d);
        e.an  = ~(4'b0001 << d);
        e.ack = prev_ack;
        e.fs  = prev_bnd;
        sb_q.push_back(e);
        prev_ack = 0;
        if (bnd && load) begin
            m_dig = digits_in; m_blank = blank_in; m_blink = blink_in;
            m_pend = 0; prev_ack = 1;
        end else if (bnd && m_pend) begin
            m_dig = p_dig; m_blank = p_blank; m_blink = p_blink;
            m_pend = 0; prev_ack = 1;
        end else if (load) begin
            p_dig = digits_in; p_blank = blank_in; p_blink = blink_in;
            m_pend = 1;
        end
        prev_bnd = bnd;
        k++;
        #1;
        o.seg = seg_n; o.an = an_n; o.ack = load_ack; o.fs = frame_start;
        e = sb_q.pop_front();
        check_val({phase_tag, ".seg"}, 32'(o.seg), 32'(e.seg));
        check_val({phase_tag, ".an"},  32'(o.an),  32'(e.an));
        check_val({phase_tag, ".ack"}, 32'(o.ack), 32'(e.ack));
        check_val({phase_tag, ".fs"},  32'(o.fs),  32'(e.fs));
        if (load_ack) ack_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] dg, input logic [3:0] bl, input logic [3:0] bk);
        digits_in = dg; blank_in = bl; blink_in = bk; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_ack(input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while (!load_ack && n < max);
        check_val({phase_tag, ".ack_seen"}, 32'(load_ack), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".seg"}, 32'(seg_n), 32'h7F);
        check_val({tag, ".an"},  32'(an_n),  32'hF);
        check_val({tag, ".ack"}, 32'(load_ack), 32'd0);
        check_val({tag, ".fs"},  32'(frame_start), 32'd0);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, holds, releases
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst.async");
        model_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_vals("rst.hold");
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int d1_dark;
        int d0_zero;
        int n;

        #2;
        apply_reset();

        // 1: scan order, first drive on digit 0
        phase_tag = "scan";
        step();
        check_val("scan.first_an", 32'(an_n), 32'hE);
        do_load(16'h1234, 4'b0000, 4'b0000);
        wait_ack(40);
        check_val("scan.ack_an",  32'(an_n),  32'hE);
        check_val("scan.ack_seg", 32'(seg_n), 32'(ref_glyph(4'h4)));
        steps(16);

        // 2: every glyph on all four digits
        phase_tag = "glyph";
        for (int v = 0; v < 16; v++) begin
            do_load({4{4'(v)}}, 4'b0000, 4'b0000);
            wait_ack(40);
            check_val("glyph.tbl", 32'(seg_n), 32'(ref_glyph(4'(v))));
            if (v == 8)  check_val("glyph.8", 32'(seg_n), 32'h00);
            if (v == 15) check_val("glyph.F", 32'(seg_n), 32'h0E);
        end

        // 3: two loads in one frame, latest wins, single ack
        phase_tag = "tear";
        n = 0;
        while (k % (S * N) != 5 && n < 32) begin step(); n++; end
        ack_cnt = 0;
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        step();
        do_load(16'h5555, 4'b0000, 4'b0000);
        steps(32);
        check_val("tear.ack_count", 32'(ack_cnt), 32'd1);
        check_val("tear.seg5", 32'(seg_n), 32'(ref_glyph(4'h5)));

        // 4: load on the wrapping tick
        phase_tag = "collide";
        lz_suppress = 1'b1;
        n = 0;
        while (!next_is_bnd() && n < 32) begin step(); n++; end
        do_load(16'h00C7, 4'b0000, 4'b0000);
        step();
        check_val("collide.ack", 32'(load_ack), 32'd1);
        check_val("collide.fs",  32'(frame_start), 32'd1);
        check_val("collide.seg", 32'(seg_n), 32'(ref_glyph(4'h7)));
        steps(16);

        // 5: blink/blank on an all-zero frame; a zero digit 1 below dark
        //    digits is itself a leading zero, so blink is seen with lz off
        phase_tag = "blink";
        do_load(16'h0000, 4'b1000, 4'b0010);
        wait_ack(40);
        d1_dark = 0; d0_zero = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an_n == 4'b1101 && seg_n == 7'h7F) d1_dark++;
            if (an_n == 4'b1110 && seg_n == 7'h40) d0_zero++;
        end
        check_val("blink.lz_d1_dark", 32'(d1_dark), 32'd16);
        check_val("blink.lz_d0_zero", 32'(d0_zero), 32'd16);
        lz_suppress = 1'b0;
        d1_dark = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (an_n == 4'b1101 && seg_n == 7'h7F) d1_dark++;
        end
        check_val("blink.d1_half_dark", 32'(d1_dark), 32'd8);

        // 6: reset mid-slot with a load pending
        phase_tag = "midrst";
        lz_suppress = 1'b1;
        n = 0;
        while (k % (S * N) != 6 && n < 32) begin step(); n++; end
        do_load(16'h9999, 4'b0000, 4'b0000);
        #2;
        apply_reset();
        ack_cnt = 0;
        step();
        check_val("midrst.first_an",  32'(an_n),  32'hE);
        check_val("midrst.first_seg", 32'(seg_n), 32'h40);
        steps(48);
        check_val("midrst.no_ack", 32'(ack_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
